// File: rtl/cache_fill_fsm.sv
// Miss handler / line-fill controller for the 2-way, 64-set cache: picks a victim, fetches the block, rewrites metadata.
// Latency: one request per cycle after acceptance; fill ends BLOCK_WORDS valids later, then one UPDATE cycle.
// Backpressure: fsm_busy stalls the pipeline for the whole fill; memory returns data whenever it likes, in order.
module cache_fill_fsm #(
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           miss_detected,
    input  logic [ADDR_W-1:0]              miss_address,
    input  logic [7:0]                     meta_way0,
    input  logic [7:0]                     meta_way1,
    input  logic [15:0]                    memory_data,
    input  logic                           memory_data_valid,
    output logic                           fsm_busy,
    output logic                           mem_read,
    output logic [ADDR_W-1:0]              memory_address,
    output logic                           write_data_array,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
    output logic [15:0]                    fill_data,
    output logic                           write_tag_array,
    output logic                           victim_way,
    output logic [5:0]                     set_index,
    output logic [15:0]                    meta_out
);

    localparam int OW    = $clog2(BLOCK_WORDS);
    localparam int CW    = OW + 1;
    localparam int TAG_W = 6;
    localparam int IDX_W = 6;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FILL   = 2'd1;
    localparam logic [1:0] S_UPDATE = 2'd2;

    logic [1:0]        state;
    logic [TAG_W-1:0]  tag_q;
    logic [IDX_W-1:0]  idx_q;
    logic              victim_q;
    logic [15:0]       meta_q;
    logic [CW-1:0]     issue_cnt;
    logic [CW-1:0]     recv_cnt;
    logic [ADDR_W-1:0] addr_hold;

    logic [TAG_W-1:0]  acc_tag;
    logic [IDX_W-1:0]  acc_idx;
    logic              vic_sel;
    logic [7:0]        new_meta0;
    logic [7:0]        new_meta1;
    logic              issuing;
    logic              wr_fire;
    logic [ADDR_W-1:0] req_addr;

    // Byte-offset and word-offset bits of the miss address are not needed: fills always start at word 0.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, miss_address[OW:0]};

    assign acc_tag = miss_address[ADDR_W-1 -: TAG_W];
    assign acc_idx = miss_address[OW+1 +: IDX_W];

    // Invalid ways are filled first; among two valid ways the one flagged LRU loses, ties go to way 0.
    always_comb begin
        vic_sel = 1'b0;
        if (!meta_way0[6]) begin
            vic_sel = 1'b0;
        end else if (!meta_way1[6]) begin
            vic_sel = 1'b1;
        end else if (meta_way1[7] && !meta_way0[7]) begin
            vic_sel = 1'b1;
        end
    end

    assign new_meta0 = vic_sel ? {1'b1, meta_way0[6:0]} : {2'b01, acc_tag};
    assign new_meta1 = vic_sel ? {2'b01, acc_tag} : {1'b1, meta_way1[6:0]};

    assign issuing  = (state == S_FILL) && (issue_cnt < CW'(BLOCK_WORDS));
    assign wr_fire  = (state == S_FILL) && memory_data_valid;
    assign req_addr = {tag_q, idx_q, issue_cnt[OW-1:0], 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            tag_q     <= '0;
            idx_q     <= '0;
            victim_q  <= 1'b0;
            meta_q    <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            addr_hold <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (miss_detected) begin
                        tag_q     <= acc_tag;
                        idx_q     <= acc_idx;
                        victim_q  <= vic_sel;
                        meta_q    <= {new_meta1, new_meta0};
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                        state     <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (issuing) begin
                        issue_cnt <= issue_cnt + 1'b1;
                        addr_hold <= req_addr;
                    end
                    // Request and data sides run independently, so any memory latency works.
                    if (memory_data_valid) begin
                        recv_cnt <= recv_cnt + 1'b1;
                        if (recv_cnt == CW'(BLOCK_WORDS - 1)) begin
                            state <= S_UPDATE;
                        end
                    end
                end
                S_UPDATE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign fsm_busy         = (state != S_IDLE);
    assign mem_read         = issuing;
    assign memory_address   = issuing ? req_addr : addr_hold;
    assign write_data_array = wr_fire;
    assign fill_word        = wr_fire ? recv_cnt[OW-1:0] : '0;
    assign fill_data        = wr_fire ? memory_data : 16'h0000;
    assign write_tag_array  = (state == S_UPDATE);
    assign victim_way       = victim_q;
    assign set_index        = idx_q;
    assign meta_out         = meta_q;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: table of fills against a latency/gap memory model, plus hold, abort and idle-valid sequences.
module tb_cache_fill_fsm;

    logic        clk;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic [7:0]  meta_way0;
    logic [7:0]  meta_way1;
    logic [15:0] memory_data;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        mem_read;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        write_tag_array;
    logic        victim_way;
    logic [5:0]  set_index;
    logic [15:0] meta_out;

    cache_fill_fsm #(.BLOCK_WORDS(8), .ADDR_W(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .meta_way0         (meta_way0),
        .meta_way1         (meta_way1),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .mem_read          (mem_read),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_word         (fill_word),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array),
        .victim_way        (victim_way),
        .set_index         (set_index),
        .meta_out          (meta_out)
    );

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  m0;
        logic [7:0]  m1;
        int          lat;
        bit          gap;
        logic        victim;
        logic [15:0] meta;
    } vec_t;

    typedef struct {
        logic [15:0] meta;
        logic        vic;
        logic [5:0]  idx;
    } meta_exp_t;

    typedef struct {
        logic [15:0] a;
        int          rdy;
    } pend_t;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_req[$];
    logic [18:0] exp_wr[$];
    meta_exp_t   exp_meta[$];
    pend_t       pend[$];

    int   cyc = 0;
    int   lat = 1;
    bit   gap_mode = 0;
    bit   extra_valid = 0;
    int   gap_ph = 0;
    int   tag_cnt = 0;
    int   tag_cyc = -10;
    int   wr_cnt = 0;
    int   req_first = 0;
    int   req_last = 0;
    bit   hold_en = 0;
    logic [5:0] hold_idx = '0;
    logic       hold_vic = 1'b0;

    vec_t vecs[7];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    task automatic push_expect(input logic [15:0] addr, input logic vic, input logic [15:0] meta);
        logic [15:0] a;
        logic [2:0]  w;
        for (int i = 0; i < 8; i++) begin
            w = 3'(i);
            a = {addr[15:4], w, 1'b0};
            exp_req.push_back(a);
            exp_wr.push_back({w, mem_word(a)});
        end
        exp_meta.push_back('{meta, vic, addr[9:4]});
    endtask

    // Memory model and output monitor: inputs are driven 1 time unit after the edge, outputs read on the falling edge.
    initial begin
        meta_exp_t m;
        bit gate;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            gate = !gap_mode || (gap_ph % 3 == 0);
            gap_ph++;
            memory_data_valid = 1'b0;
            memory_data = 16'($urandom);
            if (extra_valid) begin
                memory_data_valid = 1'b1;
                memory_data = 16'hDEAD;
            end else if (pend.size() > 0 && gate) begin
                if (pend[0].rdy <= cyc) begin
                    memory_data_valid = 1'b1;
                    memory_data = mem_word(pend[0].a);
                    void'(pend.pop_front());
                end
            end
            @(negedge clk);
            if (hold_en && fsm_busy) begin
                chk("hold_set_index", 32'(set_index), 32'(hold_idx));
                chk("hold_victim_way", 32'(victim_way), 32'(hold_vic));
            end
            if (mem_read) begin
                pend.push_back('{memory_address, cyc + lat});
                if (exp_req.size() == 0) chk("req_unexpected", 32'(mem_read), 32'd0);
                else chk("req_addr", 32'(memory_address), 32'(exp_req.pop_front()));
                if (memory_address[3:1] == 3'd0) req_first = cyc;
                req_last = cyc;
            end
            if (write_data_array) begin
                wr_cnt++;
                chk("wr_while_busy", 32'(fsm_busy), 32'd1);
                if (exp_wr.size() == 0) chk("wr_unexpected", 32'(write_data_array), 32'd0);
                else chk("wr_word_data", 32'({fill_word, fill_data}), 32'(exp_wr.pop_front()));
            end
            if (write_tag_array) begin
                if (exp_meta.size() == 0) begin
                    chk("tag_unexpected", 32'(write_tag_array), 32'd0);
                end else begin
                    m = exp_meta.pop_front();
                    chk("meta_out", 32'(meta_out), 32'(m.meta));
                    chk("victim_way", 32'(victim_way), 32'(m.vic));
                    chk("set_index", 32'(set_index), 32'(m.idx));
                end
                chk("busy_in_update", 32'(fsm_busy), 32'd1);
                tag_cnt++;
                tag_cyc = cyc;
            end else if (cyc == tag_cyc + 1) begin
                chk("busy_after_update", 32'(fsm_busy), 32'd0);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_fsm_busy"}, 32'(fsm_busy), 32'd0);
        chk({tag, "_mem_read"}, 32'(mem_read), 32'd0);
        chk({tag, "_memory_address"}, 32'(memory_address), 32'd0);
        chk({tag, "_write_data_array"}, 32'(write_data_array), 32'd0);
        chk({tag, "_fill_word"}, 32'(fill_word), 32'd0);
        chk({tag, "_fill_data"}, 32'(fill_data), 32'd0);
        chk({tag, "_write_tag_array"}, 32'(write_tag_array), 32'd0);
        chk({tag, "_victim_way"}, 32'(victim_way), 32'd0);
        chk({tag, "_set_index"}, 32'(set_index), 32'd0);
        chk({tag, "_meta_out"}, 32'(meta_out), 32'd0);
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic wait_tag(input int target);
        int n = 0;
        while (tag_cnt < target && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (tag_cnt < target) chk("tag_timeout", 32'(tag_cnt), 32'(target));
        #1;
    endtask

    task automatic expect_drained();
        chk("req_queue_empty", 32'(exp_req.size()), 32'd0);
        chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        chk("meta_queue_empty", 32'(exp_meta.size()), 32'd0);
    endtask

    task automatic run_fill(input vec_t v);
        int t0;
        lat = v.lat;
        gap_mode = v.gap;
        push_expect(v.addr, v.victim, v.meta);
        hold_idx = v.addr[9:4];
        hold_vic = v.victim;
        hold_en = 1'b1;
        miss_address = v.addr;
        meta_way0 = v.m0;
        meta_way1 = v.m1;
        miss_detected = 1'b1;
        t0 = tag_cnt;
        @(posedge clk);
        #1;
        miss_detected = 1'b0;
        miss_address = 16'($urandom);
        meta_way0 = 8'($urandom);
        meta_way1 = 8'($urandom);
        wait_tag(t0 + 1);
        hold_en = 1'b0;
        chk("req_span", 32'(req_last - req_first), 32'd7);
        repeat (2) @(posedge clk);
        #1;
        expect_drained();
    endtask

    initial begin
        int t0;
        int w0;
        int n;
        int t_upd;

        vecs[0] = '{16'h1234, 8'h00, 8'h00, 4, 1'b0, 1'b0, 16'h8044};
        vecs[1] = '{16'h2A50, 8'h45, 8'hC7, 3, 1'b0, 1'b1, 16'h4AC5};
        vecs[2] = '{16'hFFF0, 8'hC5, 8'h47, 2, 1'b0, 1'b0, 16'hC77F};
        vecs[3] = '{16'h0400, 8'h40, 8'h00, 1, 1'b1, 1'b1, 16'h41C0};
        vecs[4] = '{16'h8010, 8'hC1, 8'hC2, 1, 1'b0, 1'b0, 16'hC260};
        vecs[5] = '{16'h5550, 8'h43, 8'h44, 5, 1'b1, 1'b0, 16'hC455};
        vecs[6] = '{16'h0C0E, 8'h80, 8'h41, 1, 1'b0, 1'b0, 16'hC143};

        rst = 1'b1;
        miss_detected = 1'b0;
        miss_address = 16'h0000;
        meta_way0 = 8'h00;
        meta_way1 = 8'h00;
        memory_data = 16'h0000;
        memory_data_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            run_fill(vecs[i]);
        end

        // Miss held high across a fill with a new address: second fill must use the new address and fresh metadata.
        lat = 2;
        gap_mode = 1'b0;
        push_expect(16'h3460, 1'b0, 16'h804D);
        push_expect(16'h9A20, 1'b0, 16'hC266);
        t0 = tag_cnt;
        miss_address = 16'h3460;
        meta_way0 = 8'h00;
        meta_way1 = 8'h00;
        miss_detected = 1'b1;
        @(posedge clk);
        #1;
        miss_address = 16'h9A20;
        meta_way0 = 8'hC1;
        meta_way1 = 8'h42;
        wait_tag(t0 + 1);
        t_upd = tag_cyc;
        @(posedge clk);
        #1;
        miss_detected = 1'b0;
        wait_tag(t0 + 2);
        chk("refill_start", 32'(req_first - t_upd), 32'd2);
        repeat (2) @(posedge clk);
        #1;
        expect_drained();

        // Reset after three data words: abort with no metadata write, trailing valids ignored.
        lat = 1;
        push_expect(16'h7770, 1'b0, 16'h805D);
        miss_address = 16'h7770;
        meta_way0 = 8'h00;
        meta_way1 = 8'h00;
        miss_detected = 1'b1;
        t0 = tag_cnt;
        w0 = wr_cnt;
        @(posedge clk);
        #1;
        miss_detected = 1'b0;
        n = 0;
        while (wr_cnt < w0 + 3 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("abort_three_words", 32'(wr_cnt - w0), 32'd3);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_req.delete();
        exp_wr.delete();
        exp_meta.delete();
        w0 = wr_cnt;
        @(negedge clk);
        check_all_zero("abort");
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_tag_write", 32'(tag_cnt), 32'(t0));
        chk("abort_no_late_writes", 32'(wr_cnt), 32'(w0));

        // Stray valids in IDLE must not write the data array.
        extra_valid = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        extra_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_valid_no_write", 32'(wr_cnt), 32'(w0));
        chk("idle_still_idle", 32'(fsm_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss handler and line-fill controller for the 2-way, 64-set cache.
- Sits between the hit/miss compare logic and the metadata and data arrays.
- On a miss it picks a victim way from the two metadata bytes of the indexed set. It issues one read request per word of the block to multi-cycle memory and writes each returned word into the data array.
- It then writes the updated metadata (tag, valid, LRU) for both ways in one cycle.
- Metadata byte layout: [7]=LRU (1 = least recently used), [6]=valid, [5:0]=tag.

Parameters:
- BLOCK_WORDS, 8, 16-bit words per block. Word offset is address[3:1]; power of 2 only.
- ADDR_W, 16, byte-address width. Tag = [15:10], index = [9:4].

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- miss_detected  in  1  miss request from compare logic, level
- miss_address  in  16  byte address of the missing access
- meta_way0  in  8  metadata byte, way 0 of the indexed set
- meta_way1  in  8  metadata byte, way 1 of the indexed set
- memory_data  in  16  read data from memory
- memory_data_valid  in  1  memory_data holds the next in-order word
- fsm_busy  out  1  fill in progress; stalls the pipeline
- mem_read  out  1  read request strobe this cycle
- memory_address  out  16  address of the read request
- write_data_array  out  1  data-array write strobe
- fill_word  out  3  word offset written this cycle
- fill_data  out  16  data to data array (registered copy of memory_data is not used; combinational pass-through)
- write_tag_array  out  1  metadata write strobe (both ways)
- victim_way  out  1  way being filled (0/1)
- set_index  out  6  latched index of the fill
- meta_out  out  16  [7:0] new way-0 byte, [15:8] new way-1 byte

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst); polarity and synchronicity are fixed.
- States: IDLE, FILL, UPDATE.
- Reset: state=IDLE, counters=0, all outputs 0. Reset mid-fill aborts immediately, with no metadata write. Late memory_data_valid pulses after reset are ignored in IDLE.
- IDLE: on miss_detected=1, latch tag, index, meta_way0 and meta_way1 at the clock edge.
  - Victim selection, in priority order: way0 invalid → 0; else way1 invalid → 1; else the way whose LRU=1; both LRU=1 or both 0 → way 0.
  - Then issue_cnt=0, recv_cnt=0, go to FILL.
- FILL, request side: fsm_busy=1.
  - While issue_cnt<BLOCK_WORDS: mem_read=1 and memory_address={tag,index,issue_cnt,1'b0}; issue_cnt increments each cycle.
  - After the last request: mem_read=0 and memory_address holds its last value.
- FILL, data side: each cycle memory_data_valid=1 drives write_data_array=1, fill_word=recv_cnt and fill_data=memory_data, then recv_cnt increments.
  - No dependence on memory latency.
  - A valid arriving in the same cycle as a request is legal.
- FILL exit: after BLOCK_WORDS valids received, go to UPDATE. memory_data_valid beyond BLOCK_WORDS is ignored.
- UPDATE: one cycle, fsm_busy=1, write_tag_array=1.
  - Victim byte = {1'b0,1'b1,tag}.
  - Other way's byte = latched byte with bit7 forced to 1.
  - Next cycle: IDLE, fsm_busy=0.
- Miss handling: miss_detected is ignored while not IDLE. A miss held high is re-accepted in the cycle after return to IDLE, using fresh metadata.
- Output hold: set_index, victim_way and meta_out hold stable from acceptance through UPDATE. write_data_array and write_tag_array are 0 outside their states.
- Minimum fill time: BLOCK_WORDS + 1 cycles with 1-cycle memory latency. Latency L adds L-1 cycles.

Test Plan:
- Reset, then miss_address=0x1234 with both ways invalid, memory model latency 4 → requests to 0x1230..0x123E on 8 consecutive cycles; 8 data writes with fill_word 0..7; UPDATE meta_out[7:0]=0x44 (valid, tag 0x04), meta_out[15:8]=0x80; victim_way=0.
- Way0={LRU0,V1,tag5}=0x45, way1=0xC7 → victim_way=1; meta_out=0x4?: [15:8]=0x4T for the new tag, [7:0]=0xC5.
- Both valid, way0 LRU=1 (0xC5), way1=0x47 → victim 0; way1 byte becomes 0xC7.
- Gapped valids (pattern 1,0,0,1,...) and latency 1 → exactly 8 writes in order; write_tag_array exactly one cycle; fsm_busy deasserts the cycle after UPDATE.
- miss_detected held high during a fill and the address changed → ignored until IDLE; second fill starts the cycle after UPDATE with the new address.
- rst asserted after 3 data words → next cycle IDLE with all outputs 0 and no write_tag_array; the remaining valids cause no writes.
